// File: rtl/scan_ram_pkg.sv
// Shared types and default parameters for the scan_ram block.
package scan_ram_pkg;

  localparam int unsigned DEF_DATA_W   = 4;
  localparam int unsigned DEF_DEPTH    = 16;
  localparam int unsigned DEF_SCAN_DIV = 4;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

endpackage

// File: rtl/scan_ram_tick.sv
// Prescaler for the auto-scan pointer: pulses tick_c once every DIV cycles.
module scan_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge CLOCK_50) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/scan_ram.sv
// Clear-on-reset RAM with manual or auto-scanning registered read port.
// Define SCAN_RAM_BYPASS_EN for write-first read-during-write; default is read-first.
module scan_ram
  import scan_ram_pkg::*;
#(
  parameter  int unsigned DATA_W   = DEF_DATA_W,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  int unsigned SCAN_DIV = DEF_SCAN_DIV,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              sw,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] scan_addr,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              tick_c;
  logic              init_last;

  logic [DATA_W-1:0] mem [DEPTH];

  assign init_last = (init_cnt == ADDR_W'(DEPTH - 1));

  scan_tick #(
    .DIV (SCAN_DIV)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .clr      (state != SCAN),
    .tick_c   (tick_c)
  );

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus memory port steering; INIT owns the write port.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = waddr;
    wr_data   = din;
    rd_addr   = raddr;
    unique case (state)
      INIT: begin
        wr_en   = 1'b1;
        wr_addr = init_cnt;
        wr_data = '0;
        if (init_last) begin
          state_nxt = sw ? SCAN : MANUAL;
        end
      end
      MANUAL: begin
        wr_en = we;
        if (sw) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        wr_en   = we;
        rd_addr = ptr;
        if (!sw) begin
          state_nxt = MANUAL;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // Clear counter runs only in INIT; scan pointer is parked at 0 outside SCAN.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      init_cnt <= '0;
      ptr      <= '0;
    end else begin
      if (state == INIT) begin
        init_cnt <= init_cnt + ADDR_W'(1);
      end
      if (state != SCAN) begin
        ptr <= '0;
      end else if (tick_c) begin
        ptr <= ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (wr_en && !rst) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      dout      <= '0;
      scan_addr <= '0;
      busy      <= 1'b1;
    end else begin
      busy <= (state_nxt == INIT);
      if (state == INIT) begin
        dout      <= '0;
        scan_addr <= '0;
      end else begin
        scan_addr <= rd_addr;
`ifdef SCAN_RAM_BYPASS_EN
        dout <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
`else
        dout <= mem[rd_addr];
`endif
      end
    end
  end

endmodule

// File: tb/tb_scan_ram.sv
// Self-checking bench for scan_ram: directed scenarios plus randomized traffic vs. a memory model.
module tb_scan_ram;

  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DIV   = 4;
  localparam int unsigned AW    = 4;

  logic          CLOCK_50;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] din;
  logic [AW-1:0] raddr;
  logic          sw;
  logic [DW-1:0] dout;
  logic [AW-1:0] scan_addr;
  logic          busy;

  int            n_chk;
  int            n_fail;
  logic [DW-1:0] model [DEPTH];
`ifdef SCAN_RAM_BYPASS_EN
  bit bypass = 1'b1;
`else
  bit bypass = 1'b0;
`endif

  scan_ram #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .SCAN_DIV (DIV)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .din       (din),
    .raddr     (raddr),
    .sw        (sw),
    .dout      (dout),
    .scan_addr (scan_addr),
    .busy      (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Value a read of addr returns when a write (we_i, wa, d) lands on the same edge.
  function automatic logic [DW-1:0] rd_expect(input logic [AW-1:0] addr, input logic we_i,
                                              input logic [AW-1:0] wa, input logic [DW-1:0] d);
    if (bypass && we_i && (wa == addr)) return d;
    return model[addr];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
  endtask

  task automatic test_reset();
    int cycles;
    rst = 1'b1; we = 1'b0; sw = 1'b0; waddr = '0; din = '0; raddr = '0;
    step();
    rst = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || dout !== '0 || scan_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b dout=%0d scan_addr=%0d, required 1/0/0", busy, dout, scan_addr);
    end
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      step();
    end
    n_chk++;
    if (cycles != int'(DEPTH)) begin
      n_fail++;
      $display("FAIL busy_cycles: got %0d, required %0d", cycles, DEPTH);
    end
    clear_model();
    for (int a = 0; a < int'(DEPTH); a++) begin
      raddr = AW'(a);
      step();
      n_chk++;
      if (dout !== '0 || scan_addr !== AW'(a)) begin
        n_fail++;
        $display("FAIL reset_clear: addr %0d dout=%0d scan_addr=%0d, required 0/%0d", a, dout, scan_addr, a);
      end
    end
  endtask

  task automatic test_manual();
    logic [DW-1:0] vals [3];
    vals[0] = 4'd15; vals[1] = 4'd3; vals[2] = 4'd7;
    sw = 1'b0;
    raddr = 4'd8;
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; waddr = AW'(i); din = vals[i];
      step();
      model[i] = vals[i];
    end
    we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      raddr = AW'(i);
      step();
      n_chk++;
      if (dout !== vals[i] || scan_addr !== AW'(i)) begin
        n_fail++;
        $display("FAIL manual_read: addr %0d dout=%0d scan_addr=%0d, required %0d/%0d", i, dout, scan_addr, vals[i], i);
      end
    end
  endtask

  task automatic test_scan();
    int ea;
    we = 1'b0;
    sw = 1'b1;
    step();
    for (int k = 1; k <= int'(DEPTH * DIV) + 8; k++) begin
      step();
      ea = ((k - 1) / int'(DIV)) % int'(DEPTH);
      n_chk++;
      if (dout !== model[ea] || scan_addr !== AW'(ea)) begin
        n_fail++;
        $display("FAIL scan_seq: cycle %0d dout=%0d scan_addr=%0d, required %0d/%0d", k, dout, scan_addr, model[ea], ea);
      end
    end
    sw = 1'b0;
    step();
  endtask

  task automatic test_rdw();
    logic [DW-1:0] exp;
    sw = 1'b0;
    we = 1'b1; waddr = 4'd1; din = 4'd9; raddr = 4'd1;
    exp = rd_expect(4'd1, 1'b1, 4'd1, 4'd9);
    step();
    model[1] = 4'd9;
    we = 1'b0;
    n_chk++;
    if (dout !== exp) begin
      n_fail++;
      $display("FAIL rdw_same_edge: dout=%0d, required %0d", dout, exp);
    end
    step();
    n_chk++;
    if (dout !== 4'd9) begin
      n_fail++;
      $display("FAIL rdw_next_read: dout=%0d, required 9", dout);
    end
  endtask

  task automatic test_rst_mid_scan();
    int guard;
    int cycles;
    sw = 1'b1; we = 1'b0;
    step();
    guard = 0;
    while (scan_addr !== 4'd5 && guard < 200) begin
      guard++;
      step();
    end
    n_chk++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL scan_reach5: scan_addr=%0d, required 5 within 200 cycles", scan_addr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    sw = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || dout !== '0 || scan_addr !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_scan: busy=%b dout=%0d scan_addr=%0d, required 1/0/0", busy, dout, scan_addr);
    end
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      step();
    end
    n_chk++;
    if (cycles > int'(DEPTH) + 1) begin
      n_fail++;
      $display("FAIL rst_mid_scan_busy: got %0d cycles, required <= %0d", cycles, DEPTH + 1);
    end
    clear_model();
    for (int a = 0; a < int'(DEPTH); a++) begin
      raddr = AW'(a);
      step();
      n_chk++;
      if (dout !== '0) begin
        n_fail++;
        $display("FAIL rst_mid_scan_clear: addr %0d dout=%0d, required 0", a, dout);
      end
    end
  endtask

  task automatic test_init_write();
    int guard;
    sw = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    we = 1'b1; waddr = 4'd3; din = 4'd5;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      guard++;
      step();
    end
    we = 1'b0;
    clear_model();
    raddr = 4'd3;
    step();
    n_chk++;
    if (dout !== '0) begin
      n_fail++;
      $display("FAIL init_write_ignored: dout=%0d, required 0", dout);
    end
  endtask

  task automatic test_random_manual();
    logic [DW-1:0] exp;
    logic [AW-1:0] ra;
    sw = 1'b0;
    for (int i = 0; i < 60; i++) begin
      we    = 1'($urandom_range(0, 1));
      waddr = AW'($urandom_range(0, DEPTH - 1));
      din   = DW'($urandom);
      ra    = (i % 3 == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
      raddr = ra;
      exp   = rd_expect(ra, we, waddr, din);
      step();
      if (we) model[waddr] = din;
      n_chk++;
      if (dout !== exp || scan_addr !== ra) begin
        n_fail++;
        $display("FAIL rand_manual: iter %0d dout=%0d scan_addr=%0d, required %0d/%0d", i, dout, scan_addr, exp, ra);
      end
    end
    we = 1'b0;
  endtask

  task automatic test_random_scan();
    logic [DW-1:0] exp;
    logic [AW-1:0] ea;
    sw = 1'b1;
    we = 1'b0;
    step();
    for (int k = 1; k <= 80; k++) begin
      ea    = AW'(((k - 1) / int'(DIV)) % int'(DEPTH));
      we    = 1'($urandom_range(0, 1));
      waddr = (k % 4 == 0) ? ea : AW'($urandom_range(0, DEPTH - 1));
      din   = DW'($urandom);
      exp   = rd_expect(ea, we, waddr, din);
      step();
      if (we) model[waddr] = din;
      n_chk++;
      if (dout !== exp || scan_addr !== ea) begin
        n_fail++;
        $display("FAIL rand_scan: cycle %0d dout=%0d scan_addr=%0d, required %0d/%0d", k, dout, scan_addr, exp, ea);
      end
    end
    we = 1'b0;
    sw = 1'b0;
    step();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1; we = 1'b0; sw = 1'b0; waddr = '0; din = '0; raddr = '0;
    test_reset();
    test_manual();
    test_scan();
    test_rdw();
    test_rst_mid_scan();
    test_init_write();
    test_random_manual();
    test_random_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_ram.md
SCAN_RAM -- requirements
Module: scan_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 4, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of words; power of two, >=2.
REQ-003 SHALL have parameter SCAN_DIV, default 4, CLOCK_50 cycles per scan step; >=1.
REQ-004 SHALL derive ADDR_W = clog2(DEPTH), not user-overridable.
REQ-005 SHALL have port CLOCK_50  input  1  single clock; all state on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port we  input  1  write enable.
REQ-008 SHALL have port waddr  input  ADDR_W  write address.
REQ-009 SHALL have port din  input  DATA_W  write data.
REQ-010 SHALL have port raddr  input  ADDR_W  manual read address.
REQ-011 SHALL have port sw  input  1  0 = manual read, 1 = auto-scan read.
REQ-012 SHALL have port dout  output  DATA_W  registered read data.
REQ-013 SHALL have port scan_addr  output  ADDR_W  address that produced the current dout.
REQ-014 SHALL have port busy  output  1  high while memory clear in progress.

Function
REQ-015 SHALL implement FSM states INIT, MANUAL, SCAN.
REQ-016 INIT: write 0 to address k on cycle k, k=0..DEPTH-1; busy=1; exit after DEPTH cycles to MANUAL if sw=0 else SCAN.
REQ-017 SHALL ignore we during INIT; dout held 0.
REQ-018 MANUAL: dout = mem[raddr] one cycle after raddr sampled; scan_addr = that raddr.
REQ-019 SCAN: internal pointer advances by 1 every SCAN_DIV cycles, wraps DEPTH-1 -> 0; dout = mem[pointer] one cycle later; scan_addr = pointer of that read.
REQ-020 MANUAL->SCAN on sw=1: pointer restarts at 0, prescaler cleared; SCAN->MANUAL on sw=0 next cycle; no transition back to INIT except by rst.
REQ-021 Writes in MANUAL and SCAN: mem[waddr] <= din on edge where we=1; any waddr accepted.
REQ-022 Read-during-write same address: behaviour per REQ-027/REQ-028.
REQ-023 No arithmetic overflow: pointer and INIT counter are ADDR_W wide, wrap naturally.

Reset
REQ-024 On rst=1 at an edge: state INIT, INIT counter 0, pointer 0, prescaler 0, dout 0, scan_addr 0, busy 1.
REQ-025 rst asserted mid-INIT, mid-scan or mid-write SHALL restart INIT from address 0; write on that edge discarded.
REQ-026 Memory contents SHALL be all-zero within DEPTH+1 cycles of rst deassertion.

Configuration
REQ-027 With SCAN_RAM_BYPASS_EN defined: read of address being written on same edge returns din (write-first).
REQ-028 Without SCAN_RAM_BYPASS_EN: same case returns previous stored word (read-first).

Structure
REQ-029 Package scan_ram_pkg SHALL hold the state enum (INIT, MANUAL, SCAN) and the default parameter constants.
REQ-030 Sub-module scan_tick SHALL implement the SCAN_DIV prescaler, outputting a one-cycle tick; clearable synchronously.
REQ-031 Memory array SHALL be inferable block RAM (single write port, single read port).

Verification
REQ-032 rst pulse, then count cycles -> busy high exactly DEPTH=16 cycles, all 16 words read back 0.
REQ-033 MANUAL: write 15@0, 3@1, 7@2; read raddr 0,1,2 -> dout 15,3,7 each one cycle later, scan_addr matches.
REQ-034 SCAN with SCAN_DIV=4 after REQ-033 writes -> dout sequence 15,3,7,0,... each held 4 cycles, wraps 15->0 to 15 again.
REQ-035 we=1 waddr=1 din=9 with raddr=1 same edge -> dout 9 with SCAN_RAM_BYPASS_EN, 3 without; next read 9 both.
REQ-036 rst asserted during SCAN at pointer 5 -> busy=1, dout=0, scan_addr=0 next cycle; prior data cleared to 0.
REQ-037 Write attempted during INIT (we=1, din=5 @3) -> word 3 reads 0 after INIT.
